// File: rtl/unaligned_access_sequencer.sv
// Splits a byte/half/word access at any byte alignment into one or two accesses on a
// four-lane row-organised RAM, then merges read lanes back into a right-justified response.
module unaligned_access_sequencer #(
    parameter int unsigned ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned RowW = ADDR_W - 2;

    typedef enum logic [2:0] {
        StIdle,
        StFirst,
        StSecond,
        StLastRd,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         hi_q, hi_d;

    logic [1:0]          offset;
    logic [RowW-1:0]     row;
    logic [RowW-1:0]     row_next;
    logic [3:0]          size_mask;
    logic [7:0]          mask8;
    logic                crossing;
    logic [31:0]         byte_mask;
    logic [63:0]         wdata_dbl;
    logic [31:0]         wdata_rot;
    logic [63:0]         rdata_dbl;
    logic [31:0]         rdata_merged;

    // Request decode, all from the latched request so outputs stay stable per state.
    always_comb begin
        offset   = addr_q[1:0];
        row      = addr_q[ADDR_W-1:2];
        row_next = row + RowW'(1);

        case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        mask8    = {4'b0000, size_mask} << offset;
        crossing = |mask8[7:4];

        byte_mask = {{8{size_mask[3]}}, {8{size_mask[2]}}, {8{size_mask[1]}}, {8{size_mask[0]}}};
    end

    // Lane k carries wdata byte (k - offset) mod 4: a byte-granular left rotate.
    always_comb begin
        wdata_dbl = {wdata_q, wdata_q} << {offset, 3'b000};
        wdata_rot = wdata_dbl[63:32];
    end

    // {hi, lo} viewed as bytes 0..7; response byte i is byte (offset + i) of that pair.
    always_comb begin
        rdata_dbl    = {hi_q, lo_q} >> {offset, 3'b000};
        rdata_merged = rdata_dbl[31:0] & byte_mask;
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
        hi_d      = hi_q;

        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_be    = '0;
        ram_wdata = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = StFirst;
                end
            end

            StFirst: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_addr  = row;
                ram_be    = mask8[3:0];
                ram_wdata = wdata_rot;
                if (crossing) begin
                    state_d = StSecond;
                end else if (we_q) begin
                    state_d = StResp;
                end else begin
                    state_d = StLastRd;
                end
            end

            StSecond: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_addr  = row_next;
                ram_be    = mask8[7:4];
                ram_wdata = wdata_rot;
                // Read data returned here belongs to the FIRST access.
                lo_d      = ram_rdata;
                state_d   = we_q ? StResp : StLastRd;
            end

            StLastRd: begin
                if (crossing) begin
                    hi_d = ram_rdata;
                end else begin
                    lo_d = ram_rdata;
                end
                state_d = StResp;
            end

            StResp: begin
                rsp_valid = 1'b1;
                rsp_rdata = we_q ? 32'h0 : rdata_merged;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    a_lane_strobe_nonzero: assert property (@(posedge clk) disable iff (rst)
        ram_en |-> (ram_be != 4'b0000));

    a_rsp_held: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

    a_no_accept_while_responding: assert property (@(posedge clk) disable iff (rst)
        !(req_ready && rsp_valid));

endmodule

// File: tb/tb_unaligned_access_sequencer.sv
// Directed bench: table of single transactions against a behavioural four-lane RAM,
// plus hand-written sequences for reset and back-pressure.
module tb_unaligned_access_sequencer;

    localparam int unsigned ADDR_W = 18;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [15:0]       ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    unaligned_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous read, per-lane write; preloaded while in reset.
    bit [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0000] <= 32'h11223344;
            mem[16'h0001] <= 32'h55667788;
            mem[16'h0002] <= 32'hDEADBEEF;
            mem[16'h0003] <= 32'h0BADF00D;
            mem[16'hFFFF] <= 32'hCAFEF00D;
            ram_rdata     <= 32'h0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [17:0] addr;
        logic [31:0] wdata;
        int          n_acc;
        logic [15:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [15:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [0:12];

    int checks;
    int errors;

    int          nacc;
    int          lat;
    logic [15:0] acc_addr [0:3];
    logic [3:0]  acc_be   [0:3];
    logic        acc_we   [0:3];
    logic [31:0] acc_wd   [0:3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx, input int hold);
        string t;
        t = $sformatf("v%0d", idx);
        for (int j = 0; j < 4; j++) begin
            acc_addr[j] = '0;
            acc_be[j]   = '0;
            acc_we[j]   = 1'b0;
            acc_wd[j]   = '0;
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        check({t, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        nacc = 0;
        lat  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_en) begin
                if (nacc < 4) begin
                    acc_addr[nacc] = ram_addr;
                    acc_be[nacc]   = ram_be;
                    acc_we[nacc]   = ram_we;
                    acc_wd[nacc]   = ram_wdata;
                end
                nacc++;
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end

        check({t, "_latency"}, 32'(lat), 32'(v.lat));
        check({t, "_n_access"}, 32'(nacc), 32'(v.n_acc));
        check({t, "_addr0"}, 32'(acc_addr[0]), 32'(v.a0));
        check({t, "_be0"}, 32'(acc_be[0]), 32'(v.be0));
        check({t, "_we0"}, 32'(acc_we[0]), 32'(v.we));
        check({t, "_wdata0"}, acc_wd[0], v.wd0);
        if (v.n_acc == 2) begin
            check({t, "_addr1"}, 32'(acc_addr[1]), 32'(v.a1));
            check({t, "_be1"}, 32'(acc_be[1]), 32'(v.be1));
            check({t, "_we1"}, 32'(acc_we[1]), 32'(v.we));
            check({t, "_wdata1"}, acc_wd[1], v.wd1);
        end
        check({t, "_rdata"}, rsp_rdata, v.rdata);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({t, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({t, "_hold_rdata"}, rsp_rdata, v.rdata);
            check({t, "_hold_ready"}, 32'(req_ready), 32'd0);
            check({t, "_hold_no_access"}, 32'(ram_en), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({t, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({t, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_en;

        checks = 0;
        errors = 0;

        //        we    size   addr       wdata         n  a0      be0      wd0           a1      be1      wd1           lat rdata
        vecs[0]  = '{1'b0, 2'b01, 18'h00003, 32'h00000000, 2, 16'h0000, 4'b1000, 32'h00000000, 16'h0001, 4'b0001, 32'h00000000, 4, 32'h00008811};
        vecs[1]  = '{1'b0, 2'b00, 18'h00008, 32'h00000000, 1, 16'h0002, 4'b0001, 32'h00000000, 16'h0000, 4'b0000, 32'h00000000, 3, 32'h000000EF};
        vecs[2]  = '{1'b0, 2'b10, 18'h3FFFE, 32'h00000000, 2, 16'hFFFF, 4'b1100, 32'h00000000, 16'h0000, 4'b0011, 32'h00000000, 4, 32'h3344CAFE};
        vecs[3]  = '{1'b0, 2'b01, 18'h00006, 32'h00000000, 1, 16'h0001, 4'b1100, 32'h00000000, 16'h0000, 4'b0000, 32'h00000000, 3, 32'h00005566};
        vecs[4]  = '{1'b0, 2'b10, 18'h0000C, 32'h00000000, 1, 16'h0003, 4'b1111, 32'h00000000, 16'h0000, 4'b0000, 32'h00000000, 3, 32'h0BADF00D};
        vecs[5]  = '{1'b0, 2'b00, 18'h00007, 32'h00000000, 1, 16'h0001, 4'b1000, 32'h00000000, 16'h0000, 4'b0000, 32'h00000000, 3, 32'h00000055};
        vecs[6]  = '{1'b1, 2'b10, 18'h00005, 32'hAABBCCDD, 2, 16'h0001, 4'b1110, 32'hBBCCDDAA, 16'h0002, 4'b0001, 32'hBBCCDDAA, 3, 32'h00000000};
        vecs[7]  = '{1'b1, 2'b11, 18'h00000, 32'h01020304, 1, 16'h0000, 4'b1111, 32'h01020304, 16'h0000, 4'b0000, 32'h00000000, 2, 32'h00000000};
        vecs[8]  = '{1'b1, 2'b01, 18'h00011, 32'h0000BEEF, 1, 16'h0004, 4'b0110, 32'h00BEEF00, 16'h0000, 4'b0000, 32'h00000000, 2, 32'h00000000};
        vecs[9]  = '{1'b1, 2'b00, 18'h0001F, 32'h000000A5, 1, 16'h0007, 4'b1000, 32'hA5000000, 16'h0000, 4'b0000, 32'h00000000, 2, 32'h00000000};
        vecs[10] = '{1'b1, 2'b01, 18'h00017, 32'h00001234, 2, 16'h0005, 4'b1000, 32'h34000012, 16'h0006, 4'b0001, 32'h34000012, 3, 32'h00000000};
        vecs[11] = '{1'b0, 2'b01, 18'h00017, 32'h00000000, 2, 16'h0005, 4'b1000, 32'h00000000, 16'h0006, 4'b0001, 32'h00000000, 4, 32'h00001234};
        vecs[12] = '{1'b0, 2'b10, 18'h00010, 32'h00000000, 1, 16'h0004, 4'b1111, 32'h00000000, 16'h0000, 4'b0000, 32'h00000000, 3, 32'h00BEEF00};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_be", 32'(ram_be), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i <= 12; i++) begin
            do_txn(vecs[i], i, (i == 1) ? 5 : 0);
        end

        // Reset while the second half of a crossing write is on the lanes.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 18'h00025;
        req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rr_first_be", 32'(ram_be), 32'(4'b1110));
        check("rr_first_addr", 32'(ram_addr), 32'h0009);
        @(negedge clk);
        check("rr_second_be", 32'(ram_be), 32'(4'b0001));
        check("rr_second_addr", 32'(ram_addr), 32'h000A);
        rst = 1'b1;
        #1;
        check("rr_ram_en", 32'(ram_en), 32'd0);
        check("rr_ram_be", 32'(ram_be), 32'd0);
        check("rr_ram_we", 32'(ram_we), 32'd0);
        check("rr_ram_addr", 32'(ram_addr), 32'd0);
        check("rr_ram_wdata", ram_wdata, 32'd0);
        check("rr_req_ready", 32'(req_ready), 32'd0);
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rr_post_req_ready", 32'(req_ready), 32'd1);
        seen_en = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ram_en || rsp_valid) seen_en++;
        end
        check("rr_no_further_activity", 32'(seen_en), 32'd0);
        check("rr_row9_first_half", mem[16'h0009], 32'hBBCCDD00);
        check("rr_row10_untouched", mem[16'h000A], 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
